// File: rtl/add_8bit_signed_serial.sv
`default_nettype none
// =============================================================================
// add_8bit_signed_serial : bit-serial two's-complement adder (LSB first, one
//                          full-adder cell) with valid/ready on both sides.
// Revision: 1.0
// =============================================================================
module add_8bit_signed_serial #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MAXNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sum_word;
  logic [WIDTH-1:0] w_final;

  // Operands shift right each bit, so bit 0 is always the bit being added;
  // on the last step bit 0 holds the original sign bits.
  assign w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last      = (r_count == C_LAST);
  assign w_sum_word  = {w_sum_bit, r_result[WIDTH-1:1]};
  assign w_ovf       = (r_a[0] == r_b[0]) && (w_sum_bit != r_a[0]);

  generate
    if (SATURATE) begin : g_sat
      assign w_final = w_ovf ? (r_a[0] ? C_MAXNEG : C_MAXPOS) : w_sum_word;
    end else begin : g_wrap
      assign w_final = w_sum_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_count    <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= 1'b0;
            r_count <= '0;
          end
        end
        S_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry_nxt;
          r_count <= r_count + CNT_W'(1);
          if (w_last) begin
            r_result   <= w_final;
            r_overflow <= w_ovf;
          end else begin
            r_result   <= w_sum_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_add_8bit_signed_serial.sv
`default_nettype none
// =============================================================================
// tb_add_8bit_signed_serial : directed bench, wrap and saturating instances.
// Revision: 1.0
// =============================================================================
module tb_add_8bit_signed_serial;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;

  logic             in_ready_w, out_valid_w, overflow_w, busy_w;
  logic [WIDTH-1:0] result_w;
  logic             in_ready_s, out_valid_s, overflow_s, busy_s;
  logic [WIDTH-1:0] result_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  add_8bit_signed_serial #(.WIDTH(WIDTH), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .A(A), .B(B), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .overflow(overflow_w), .busy(busy_w)
  );

  add_8bit_signed_serial #(.WIDTH(WIDTH), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .overflow(overflow_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: accept, measure latency, optional backpressure with
  // junk operands on in_valid, then result handshake.
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_w, input logic [7:0] exp_s,
                        input logic exp_o, input int hold, input bit noise);
    int lat;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready_w, 1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 8'h55; B = 8'h55;
    check("shift_busy", busy_w, 1);
    check("shift_in_ready", in_ready_w, 0);
    lat = 0;
    while (!out_valid_w && lat < 20) begin
      if (noise) begin
        in_valid = ~in_valid;
        A = 8'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 8);
    check("result_wrap", result_w, exp_w);
    check("result_sat", result_s, exp_s);
    check("ovf_wrap", overflow_w, exp_o);
    check("ovf_sat", overflow_s, exp_o);
    check("done_valid_sat", out_valid_s, 1);
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = ~in_valid;
        A = 8'($urandom);
        B = 8'($urandom);
      end
      @(posedge clk); #1;
      check("hold_valid", out_valid_w, 1);
      check("hold_result", result_w, exp_w);
      check("hold_in_ready", in_ready_w, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid_w, 0);
    check("post_hs_in_ready", in_ready_w, 1);
  endtask

  logic [7:0] st_a [8] = '{8'h32, 8'h9C, 8'h7F, 8'hFF, 8'h7F, 8'h00, 8'hC0, 8'h40};
  logic [7:0] st_b [8] = '{8'h3C, 8'hCE, 8'h01, 8'hFF, 8'h80, 8'h00, 8'hC0, 8'h40};
  logic [7:0] st_w [8] = '{8'h6E, 8'h6A, 8'h80, 8'hFE, 8'hFF, 8'h00, 8'h80, 8'h80};
  logic [7:0] st_s [8] = '{8'h6E, 8'h80, 8'h7F, 8'hFE, 8'hFF, 8'h00, 8'h80, 8'h7F};
  logic       st_o [8] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};

  task automatic stream();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int last = 0;
    out_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid_w) begin
        check("stream_res_wrap", result_w, st_w[got]);
        check("stream_res_sat", result_s, st_s[got]);
        check("stream_ovf", overflow_w, st_o[got]);
        if (got > 0) check("stream_period", cyc - last, 10);
        last = cyc;
        got++;
      end
      if (in_ready_w && idx < 8) begin
        A = st_a[idx]; B = st_b[idx]; in_valid = 1'b1;
        idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("stream_count", got, 8);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_in_ready", in_ready_w, 1);
    check("rst_out_valid", out_valid_w, 0);
    check("rst_busy", busy_w, 0);
    check("rst_result", result_w, 0);
    check("rst_overflow", overflow_s, 0);
    #20 rst_n = 1'b1;

    do_txn(8'd100, 8'd27, 8'h7F, 8'h7F, 1'b0, 0, 1'b0);
    do_txn(8'd100, 8'd28, 8'h80, 8'h7F, 1'b1, 0, 1'b0);
    do_txn(8'h80,  8'hFF, 8'h7F, 8'h80, 1'b1, 0, 1'b0);
    do_txn(8'hFB,  8'h03, 8'hFE, 8'hFE, 1'b0, 0, 1'b0);
    do_txn(8'hEC,  8'hE2, 8'hCE, 8'hCE, 1'b0, 5, 1'b1);

    // Asynchronous reset in the middle of a shift, away from any edge.
    @(posedge clk); #1;
    A = 8'd5; B = 8'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready_w, 1);
    check("midrst_busy", busy_w, 0);
    check("midrst_out_valid", out_valid_s, 0);
    check("midrst_result", result_w, 0);
    check("midrst_overflow", overflow_w, 0);
    #2 rst_n = 1'b1;

    do_txn(8'd1, 8'd1, 8'd2, 8'd2, 1'b0, 0, 1'b0);
    stream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
